// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths and control bundle layout for the 20-bit pipeline
package pipeline_pkg;

  localparam int DEFAULT_DATA_WIDTH = 20;
  localparam int DEFAULT_REG_NUMBER = 5;
  localparam int DEFAULT_CTRL_WIDTH = 8;

  // Bit positions inside the control bundle
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_ALU_OP_LSB = 3;
  localparam int CTRL_ALU_OP_MSB = 7;

  // Declared MSB first so that reg_write lands on bit 0
  typedef struct packed {
    logic [4:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare producing the ID stall request
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_NUMBER = DEFAULT_REG_NUMBER
) (
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_NUMBER-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_NUMBER-1:0] id_rs1,
  input  logic [REG_NUMBER-1:0] id_rs2,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  id_stall
);

  logic load_use;

  // A load in EX whose destination is read by the ID instruction needs one bubble;
  // flush, hold and reset all override the request so IF/ID never freezes needlessly
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    id_stall = load_use && rst && !flush && !ex_hold;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with write-back bypass and load-use bubble
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_NUMBER = DEFAULT_REG_NUMBER,
  parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_NUMBER-1:0] id_rs1,
  input  logic [REG_NUMBER-1:0] id_rs2,
  input  logic [REG_NUMBER-1:0] id_rd,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [DATA_WIDTH-1:0] data_rs1,
  input  logic [DATA_WIDTH-1:0] data_rs2,
  input  logic                  wb_reg_write,
  input  logic [REG_NUMBER-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  input  logic                  ex_hold,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [REG_NUMBER-1:0] ex_rs1,
  output logic [REG_NUMBER-1:0] ex_rs2,
  output logic [REG_NUMBER-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0] ex_op_a,
  output logic [DATA_WIDTH-1:0] ex_op_b,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [CTRL_WIDTH-1:0] ex_ctrl
);

  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  // Register file returns stale data for a same-cycle write, so bypass WB; x0 is always zero
  always_comb begin
    op_a = data_rs1;
    if (id_rs1 == '0) begin
      op_a = '0;
    end else if (wb_reg_write && (wb_rd == id_rs1)) begin
      op_a = wb_data;
    end
    op_b = data_rs2;
    if (id_rs2 == '0) begin
      op_b = '0;
    end else if (wb_reg_write && (wb_rd == id_rs2)) begin
      op_b = wb_data;
    end
  end

  hazard_detect #(
    .REG_NUMBER (REG_NUMBER)
  ) u_hazard_detect (
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .ex_hold     (ex_hold),
    .id_stall    (id_stall)
  );

  // EX register: reset, then flush bubble, then hold, then stall bubble, then normal load
  always_ff @(posedge clk) begin
    if (!rst || flush || (!ex_hold && id_stall)) begin
      ex_valid <= 1'b0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_op_a  <= '0;
      ex_op_b  <= '0;
      ex_imm   <= '0;
      ex_ctrl  <= '0;
    end else if (!ex_hold) begin
      ex_valid <= id_valid;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_op_a  <= op_a;
      ex_op_b  <= op_b;
      ex_imm   <= id_imm;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic [19:0] id_imm, data_rs1, data_rs2;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [19:0] wb_data;
  logic        flush, ex_hold;
  logic        id_stall, ex_valid;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [19:0] ex_op_a, ex_op_b, ex_imm;
  logic [7:0]  ex_ctrl;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [19:0] op_a;
    logic [19:0] op_b;
    logic [19:0] imm;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t sb_q[$];
  ex_t model = '0;
  int  checks = 0;
  int  failures = 0;

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_ctrl      (id_ctrl),
    .id_imm       (id_imm),
    .data_rs1     (data_rs1),
    .data_rs2     (data_rs2),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_hold      (ex_hold),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_op_a      (ex_op_a),
    .ex_op_b      (ex_op_b),
    .ex_imm       (ex_imm),
    .ex_ctrl      (ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] operand(input logic [4:0] rs, input logic [19:0] rf);
    if (rs == 5'd0) return 20'd0;
    if (wb_reg_write && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic exp_stall();
    return rst && !flush && !ex_hold && model.valid && model.ctrl[CTRL_MEM_READ] &&
           model.rd != 5'd0 && id_valid && (model.rd == id_rs1 || model.rd == id_rs2);
  endfunction

  function automatic logic [7:0] mk_ctrl(input logic rw, input logic mr, input logic mw, input logic [4:0] alu);
    ctrl_t c;
    c.alu_op = alu;
    c.mem_write = mw;
    c.mem_read = mr;
    c.reg_write = rw;
    return c;
  endfunction

  // One clock: check the combinational stall, predict the EX register, clock, compare
  task automatic step(input string tag);
    ex_t n;
    logic st;
    ex_t got;
    #1;
    st = exp_stall();
    chk({tag, ".id_stall"}, {31'd0, id_stall}, {31'd0, st});
    if (!rst || flush) n = '0;
    else if (ex_hold) n = model;
    else if (st) n = '0;
    else begin
      n.valid = id_valid;
      n.rs1   = id_rs1;
      n.rs2   = id_rs2;
      n.rd    = id_rd;
      n.op_a  = operand(id_rs1, data_rs1);
      n.op_b  = operand(id_rs2, data_rs2);
      n.imm   = id_imm;
      n.ctrl  = id_valid ? id_ctrl : 8'd0;
    end
    sb_q.push_back(n);
    @(posedge clk);
    #1;
    model = sb_q.pop_front();
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, model.valid});
    chk({tag, ".ex_rs1"},   {27'd0, ex_rs1},   {27'd0, model.rs1});
    chk({tag, ".ex_rs2"},   {27'd0, ex_rs2},   {27'd0, model.rs2});
    chk({tag, ".ex_rd"},    {27'd0, ex_rd},    {27'd0, model.rd});
    chk({tag, ".ex_op_a"},  {12'd0, ex_op_a},  {12'd0, model.op_a});
    chk({tag, ".ex_op_b"},  {12'd0, ex_op_b},  {12'd0, model.op_b});
    chk({tag, ".ex_imm"},   {12'd0, ex_imm},   {12'd0, model.imm});
    chk({tag, ".ex_ctrl"},  {24'd0, ex_ctrl},  {24'd0, model.ctrl});
    got = '0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ctrl = 0; id_imm = 0;
    data_rs1 = 0; data_rs2 = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    flush = 0; ex_hold = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [7:0] ctrl, input logic [19:0] d1, input logic [19:0] d2,
                       input logic [19:0] imm);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    data_rs1 = d1; data_rs2 = d2; id_imm = imm;
  endtask

  initial begin
    idle();
    // Reset with random inputs
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_rd = 5'($urandom); id_ctrl = 8'($urandom); id_imm = 20'($urandom);
      data_rs1 = 20'($urandom); data_rs2 = 20'($urandom); wb_reg_write = 1'($urandom);
      wb_rd = 5'($urandom); wb_data = 20'($urandom); flush = 1'($urandom); ex_hold = 1'($urandom);
      step("reset");
    end
    chk("reset.ex_valid_zero", {31'd0, ex_valid}, 32'd0);
    chk("reset.ex_ctrl_zero", {24'd0, ex_ctrl}, 32'd0);
    idle();
    rst = 1;
    step("idle");

    // Pass-through
    issue(5'd3, 5'd4, 5'd6, mk_ctrl(1, 0, 0, 5'd1), 20'h00ABC, 20'h00555, 20'hFFFF0);
    step("pass");
    chk("pass.op_a", {12'd0, ex_op_a}, 32'h00ABC);
    chk("pass.imm", {12'd0, ex_imm}, 32'hFFFF0);
    chk("pass.valid", {31'd0, ex_valid}, 32'd1);

    // WB bypass, then x0 never bypassed
    issue(5'd9, 5'd7, 5'd10, mk_ctrl(1, 0, 0, 5'd2), 20'h00777, 20'h00001, 20'h00010);
    wb_reg_write = 1; wb_rd = 5'd7; wb_data = 20'h12345;
    step("bypass");
    chk("bypass.op_b", {12'd0, ex_op_b}, 32'h12345);
    id_rs2 = 5'd0;
    step("bypass_x0");
    chk("bypass_x0.op_b", {12'd0, ex_op_b}, 32'd0);
    id_rs1 = 5'd0; wb_rd = 5'd0; data_rs1 = 20'h0F0F0;
    step("wb_rd0");
    chk("wb_rd0.op_a", {12'd0, ex_op_a}, 32'd0);
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;

    // Load-use: one-cycle bubble then normal load
    issue(5'd1, 5'd0, 5'd5, mk_ctrl(1, 1, 0, 5'd0), 20'h00100, 20'h0, 20'h00004);
    step("load");
    issue(5'd5, 5'd2, 5'd8, mk_ctrl(1, 0, 0, 5'd3), 20'h00111, 20'h00222, 20'h0);
    #1;
    chk("loaduse.stall_high", {31'd0, id_stall}, 32'd1);
    step("loaduse");
    chk("loaduse.bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("loaduse.bubble_ctrl", {24'd0, ex_ctrl}, 32'd0);
    chk("loaduse.stall_drops", {31'd0, id_stall}, 32'd0);
    step("loaduse_retry");
    chk("loaduse.retry_rd", {27'd0, ex_rd}, 32'd8);
    chk("loaduse.retry_valid", {31'd0, ex_valid}, 32'd1);

    // Flush wins over a pending hazard
    issue(5'd1, 5'd0, 5'd5, mk_ctrl(1, 1, 0, 5'd0), 20'h00100, 20'h0, 20'h00004);
    step("load2");
    issue(5'd3, 5'd5, 5'd9, mk_ctrl(1, 0, 1, 5'd4), 20'h00333, 20'h00444, 20'h0);
    flush = 1;
    #1;
    chk("flush.stall_low", {31'd0, id_stall}, 32'd0);
    step("flush");
    chk("flush.bubble_valid", {31'd0, ex_valid}, 32'd0);
    flush = 0;

    // Hold wins for three cycles, hazard re-evaluated after it drops
    issue(5'd1, 5'd0, 5'd5, mk_ctrl(1, 1, 0, 5'd0), 20'h00ABC, 20'h0, 20'h00008);
    step("load3");
    issue(5'd5, 5'd6, 5'd11, mk_ctrl(1, 0, 0, 5'd5), 20'h00999, 20'h00888, 20'h0);
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      data_rs1 = 20'($urandom);
      step("hold");
      chk("hold.rd_kept", {27'd0, ex_rd}, 32'd5);
      chk("hold.stall_low", {31'd0, id_stall}, 32'd0);
    end
    ex_hold = 0;
    #1;
    chk("hold.stall_after", {31'd0, id_stall}, 32'd1);
    step("hold_release");

    // Reset mid-stall
    issue(5'd1, 5'd0, 5'd5, mk_ctrl(1, 1, 0, 5'd0), 20'h00001, 20'h0, 20'h0);
    step("load4");
    issue(5'd5, 5'd5, 5'd12, mk_ctrl(1, 0, 0, 5'd0), 20'h00002, 20'h00003, 20'h0);
    rst = 0;
    #1;
    chk("rst_mid.stall_low", {31'd0, id_stall}, 32'd0);
    step("rst_mid");
    rst = 1;
    idle();
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
